// File: rtl/path_mailbox_slave.sv
// Memory-mapped path-planning mailbox shared between a host and a RISC-V core.
// CPU stores to NODE feed a host-drained FIFO. A CPU store of 1 to DONE latches completion.
module path_mailbox_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          NODE_W     = 5,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  PREV_RST   = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  input  logic                          ext_we,
  input  logic [31:0]                   ext_addr,
  input  logic [31:0]                   ext_wdata,
  output logic                          hit,
  output logic                          node_valid,
  output logic [NODE_W-1:0]             node_data,
  input  logic                          node_pop,
  output logic [$clog2(FIFO_DEPTH):0]   node_count,
  output logic                          overflow,
  output logic                          cpu_done
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int NREG     = 5;
  localparam int R_START  = 0;
  localparam int R_END    = 1;
  localparam int R_NODE   = 2;
  localparam int R_DONE   = 3;
  localparam int R_PREV   = 4;

  function automatic logic decode_hit(input logic [31:0] a);
    return (a[31:5] == BASE_ADDR[31:5]) && (a[1:0] == 2'b00) && (a[4:2] <= 3'd4);
  endfunction

  logic            cpu_hit;
  logic            ext_hit;
  logic [NREG-1:0] ext_sel;
  logic [NREG-1:0] cpu_sel;

  assign cpu_hit = decode_hit(cpu_addr);
  assign ext_hit = decode_hit(ext_addr);

  // Host writes take priority; a colliding CPU store loses all of its side effects.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sel
      assign ext_sel[gi] = ext_we && ext_hit && (ext_addr[4:2] == 3'(gi));
      assign cpu_sel[gi] = cpu_we && cpu_hit && (cpu_addr[4:2] == 3'(gi)) && !ext_sel[gi];
    end
  endgenerate

  logic [31:0]      start_q, start_d;
  logic [31:0]      end_q,   end_d;
  logic [31:0]      node_q,  node_d;
  logic [31:0]      prev_q,  prev_d;
  logic             done_q,  done_d;
  logic             ovf_q,   ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic [NODE_W-1:0] fifo_mem [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic do_push;
  logic do_pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_req   = cpu_sel[R_NODE] && !done_q;
  assign do_pop     = node_pop && !fifo_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push    = push_req && (!fifo_full || do_pop);

  always_comb begin
    start_d  = start_q;
    end_d    = end_q;
    node_d   = node_q;
    prev_d   = prev_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (ext_sel[R_START])      start_d = ext_wdata;
    else if (cpu_sel[R_START]) start_d = cpu_wdata;

    if (ext_sel[R_END])        end_d = ext_wdata;
    else if (cpu_sel[R_END])   end_d = cpu_wdata;

    if (ext_sel[R_NODE])       node_d = ext_wdata;
    else if (cpu_sel[R_NODE])  node_d = cpu_wdata;

    if (ext_sel[R_PREV])       prev_d = ext_wdata;
    else if (cpu_sel[R_PREV])  prev_d = cpu_wdata;

    if (ext_sel[R_DONE])                         done_d = ext_wdata[0];
    else if (cpu_sel[R_DONE] && cpu_wdata[0])    done_d = 1'b1;

    if (push_req && fifo_full && !do_pop) ovf_d = 1'b1;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q  <= '0;
      end_q    <= '0;
      node_q   <= '0;
      prev_q   <= {24'h0, PREV_RST};
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      start_q  <= start_d;
      end_q    <= end_d;
      node_q   <= node_d;
      prev_q   <= prev_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= cpu_wdata[NODE_W-1:0];
  end

  always_comb begin
    cpu_rdata = '0;
    if (cpu_hit) begin
      case (cpu_addr[4:2])
        3'd0:    cpu_rdata = start_q;
        3'd1:    cpu_rdata = end_q;
        3'd2:    cpu_rdata = node_q;
        3'd3:    cpu_rdata = {31'h0, done_q};
        3'd4:    cpu_rdata = prev_q;
        default: cpu_rdata = '0;
      endcase
    end
  end

  assign hit        = cpu_hit;
  assign node_valid = !fifo_empty;
  assign node_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign node_count = count_q;
  assign overflow   = ovf_q;
  assign cpu_done   = done_q;

endmodule

// File: tb/tb_path_mailbox_slave.sv
// Scoreboard bench for path_mailbox_slave: stimulus queues expectations, a negedge monitor checks them.
module tb_path_mailbox_slave;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] A_START = BASE + 32'h00;
  localparam logic [31:0] A_END   = BASE + 32'h04;
  localparam logic [31:0] A_NODE  = BASE + 32'h08;
  localparam logic [31:0] A_DONE  = BASE + 32'h0C;
  localparam logic [31:0] A_PREV  = BASE + 32'h10;

  localparam int K_RDATA = 0;
  localparam int K_HIT   = 1;
  localparam int K_COUNT = 2;
  localparam int K_VALID = 3;
  localparam int K_DATA  = 4;
  localparam int K_OVF   = 5;
  localparam int K_DONE  = 6;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        hit;
  logic        node_valid;
  logic [4:0]  node_data;
  logic        node_pop;
  logic [4:0]  node_count;
  logic        overflow;
  logic        cpu_done;

  int errors = 0;
  int checks = 0;

  int          kind_q [$];
  logic [31:0] val_q  [$];
  string       name_q [$];
  logic [4:0]  node_exp_q [$];

  path_mailbox_slave dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .hit        (hit),
    .node_valid (node_valid),
    .node_data  (node_data),
    .node_pop   (node_pop),
    .node_count (node_count),
    .overflow   (overflow),
    .cpu_done   (cpu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input int kind, input logic [31:0] v, input string name);
    kind_q.push_back(kind);
    val_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains queued expectations and checks every accepted pop against the node queue.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      int          k;
      logic [31:0] v;
      logic [31:0] act;
      string       nm;
      k   = kind_q.pop_front();
      v   = val_q.pop_front();
      nm  = name_q.pop_front();
      act = '0;
      case (k)
        K_RDATA: act = cpu_rdata;
        K_HIT:   act = {31'h0, hit};
        K_COUNT: act = {27'h0, node_count};
        K_VALID: act = {31'h0, node_valid};
        K_DATA:  act = {27'h0, node_data};
        K_OVF:   act = {31'h0, overflow};
        K_DONE:  act = {31'h0, cpu_done};
        default: act = 32'hDEAD_BEEF;
      endcase
      checks++;
      if (act !== v) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, v);
      end else begin
        $display("ok   %s: 0x%08h", nm, act);
      end
    end
    if (reset && node_pop && node_valid) begin
      checks++;
      if (node_exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0d expected no entry", node_data);
      end else begin
        logic [4:0] e;
        e = node_exp_q.pop_front();
        if (node_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %0d expected %0d", node_data, e);
        end else begin
          $display("ok   pop_data: %0d", node_data);
        end
      end
    end
  end

  task automatic idle();
    cpu_we = 1'b0; ext_we = 1'b0; node_pop = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; ext_addr = '0; ext_wdata = '0;
  endtask

  initial begin
    logic [31:0] reset_vals [5];
    reset_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF};
    idle();
    reset = 1'b0;
    cyc();
    expect_val(K_COUNT, 32'd0, "rst_count");
    expect_val(K_VALID, 32'd0, "rst_valid");
    cyc();
    reset = 1'b1;

    // Reset values of every register
    for (int i = 0; i < 5; i++) begin
      cpu_addr = BASE + 32'(4 * i);
      expect_val(K_RDATA, reset_vals[i], $sformatf("rst_read_off%0d", 4 * i));
      expect_val(K_HIT, 32'd1, "rst_hit");
      cyc();
    end
    expect_val(K_DONE, 32'd0, "rst_done");
    expect_val(K_OVF, 32'd0, "rst_ovf");
    expect_val(K_DATA, 32'd0, "rst_node_data");
    cyc();

    // Host preload
    ext_we = 1'b1;
    ext_addr = A_START; ext_wdata = 32'd3;   cyc();
    ext_addr = A_END;   ext_wdata = 32'd11;  cyc();
    ext_addr = A_PREV;  ext_wdata = 32'd255; cyc();
    ext_we = 1'b0;
    cpu_addr = A_START; expect_val(K_RDATA, 32'd3, "read_start");  cyc();
    cpu_addr = A_END;   expect_val(K_RDATA, 32'd11, "read_end");   cyc();
    cpu_addr = A_PREV;  expect_val(K_RDATA, 32'd255, "read_prev"); cyc();
    ext_we = 1'b1; ext_addr = A_PREV; ext_wdata = 32'h0000_1234; cyc();
    ext_we = 1'b0;
    expect_val(K_RDATA, 32'h0000_1234, "read_prev2"); cyc();

    // Three NODE stores, then drain
    cpu_we = 1'b1; cpu_addr = A_NODE;
    cpu_wdata = 32'd3;  cyc();
    expect_val(K_COUNT, 32'd1, "cnt_after_3");
    expect_val(K_DATA, 32'd3, "head_after_3");
    cpu_wdata = 32'd7;  cyc();
    expect_val(K_COUNT, 32'd2, "cnt_after_7");
    cpu_wdata = 32'd11; cyc();
    cpu_we = 1'b0;
    expect_val(K_COUNT, 32'd3, "cnt_after_11");
    expect_val(K_RDATA, 32'd11, "read_node_11");
    cyc();
    node_pop = 1'b1;
    node_exp_q.push_back(5'd3);  cyc();
    node_exp_q.push_back(5'd7);  cyc();
    node_exp_q.push_back(5'd11); cyc();
    node_pop = 1'b0;
    expect_val(K_COUNT, 32'd0, "cnt_drained");
    expect_val(K_VALID, 32'd0, "valid_drained");
    expect_val(K_DATA, 32'd0, "data_drained");
    cyc();

    // Fill to full and overflow with the 17th store
    cpu_we = 1'b1; cpu_addr = A_NODE;
    for (int i = 0; i < 17; i++) begin
      cpu_wdata = 32'(i + 1);
      if (i == 16) begin
        expect_val(K_COUNT, 32'd16, "cnt_full");
        expect_val(K_OVF, 32'd0, "ovf_before");
      end
      cyc();
    end
    cpu_we = 1'b0;
    expect_val(K_COUNT, 32'd16, "cnt_after_drop");
    expect_val(K_OVF, 32'd1, "ovf_after");
    expect_val(K_DATA, 32'd1, "head_after_drop");
    cyc();
    cpu_we = 1'b1; cpu_wdata = 32'd20; node_pop = 1'b1;
    node_exp_q.push_back(5'd1);
    cyc();
    cpu_we = 1'b0; node_pop = 1'b0;
    expect_val(K_COUNT, 32'd16, "cnt_pushpop_full");
    expect_val(K_DATA, 32'd2, "head_pushpop_full");
    cyc();
    node_pop = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      node_exp_q.push_back(5'(i));
      cyc();
    end
    node_exp_q.push_back(5'd20);
    cyc();
    node_pop = 1'b0;
    expect_val(K_COUNT, 32'd0, "cnt_empty_again");
    expect_val(K_OVF, 32'd1, "ovf_sticky");
    cyc();

    // DONE: store 0 ignored, store 1 sets, then NODE is frozen
    cpu_we = 1'b1; cpu_addr = A_DONE; cpu_wdata = 32'd0; cyc();
    cpu_we = 1'b0;
    expect_val(K_DONE, 32'd0, "done_write0");
    cyc();
    cpu_we = 1'b1; cpu_wdata = 32'd1; cyc();
    cpu_we = 1'b0;
    expect_val(K_DONE, 32'd1, "done_set");
    expect_val(K_RDATA, 32'd1, "read_done");
    cyc();
    cpu_we = 1'b1; cpu_addr = A_NODE; cpu_wdata = 32'd9; cyc();
    cpu_we = 1'b0;
    expect_val(K_RDATA, 32'd9, "read_node_frozen");
    expect_val(K_COUNT, 32'd0, "cnt_frozen");
    expect_val(K_VALID, 32'd0, "valid_frozen");
    cyc();

    // Host clears DONE; collisions are won by the host
    ext_we = 1'b1; ext_addr = A_DONE; ext_wdata = 32'd0; cyc();
    ext_we = 1'b0;
    expect_val(K_DONE, 32'd0, "done_ext_clear");
    cyc();
    ext_we = 1'b1; ext_addr = A_DONE; ext_wdata = 32'd0;
    cpu_we = 1'b1; cpu_addr = A_DONE; cpu_wdata = 32'd1;
    cyc();
    idle();
    expect_val(K_DONE, 32'd0, "done_collision");
    cyc();
    ext_we = 1'b1; ext_addr = A_NODE; ext_wdata = 32'd6;
    cpu_we = 1'b1; cpu_addr = A_NODE; cpu_wdata = 32'd5;
    cyc();
    idle();
    cpu_addr = A_NODE;
    expect_val(K_RDATA, 32'd6, "node_collision");
    expect_val(K_COUNT, 32'd0, "cnt_collision");
    cyc();
    ext_we = 1'b1; ext_addr = A_NODE; ext_wdata = 32'd4; cyc();
    ext_we = 1'b0;
    expect_val(K_COUNT, 32'd0, "cnt_ext_node");
    cyc();

    // Address decode boundaries
    cpu_we = 1'b1; cpu_addr = BASE + 32'h14; cpu_wdata = 32'hAA;
    expect_val(K_HIT, 32'd0, "hit_0x14");
    expect_val(K_RDATA, 32'd0, "rdata_0x14");
    cyc();
    cpu_we = 1'b0; cpu_addr = BASE + 32'h01;
    expect_val(K_HIT, 32'd0, "hit_misaligned");
    cyc();
    cpu_addr = 32'h0300_0008;
    expect_val(K_HIT, 32'd0, "hit_other_base");
    expect_val(K_RDATA, 32'd0, "rdata_other_base");
    cyc();
    cpu_addr = A_START;
    expect_val(K_RDATA, 32'd3, "start_untouched");
    cyc();

    // Asynchronous reset mid-operation
    cpu_we = 1'b1; cpu_addr = A_NODE; cpu_wdata = 32'd12; cyc();
    cpu_we = 1'b0;
    expect_val(K_COUNT, 32'd1, "cnt_before_reset");
    cyc();
    reset = 1'b0;
    cpu_addr = A_PREV;
    expect_val(K_COUNT, 32'd0, "cnt_async_reset");
    expect_val(K_VALID, 32'd0, "valid_async_reset");
    expect_val(K_OVF, 32'd0, "ovf_async_reset");
    expect_val(K_RDATA, 32'hFF, "prev_async_reset");
    cyc();
    reset = 1'b1;
    cpu_addr = A_START;
    expect_val(K_RDATA, 32'd0, "start_after_reset");
    cyc();
    cyc();

    checks++;
    if (node_exp_q.size() != 0) begin
      errors++;
      $display("FAIL pops_outstanding: got %0d left expected 0", node_exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
